// File: rtl/pga_alarm_ctrl.sv
// Peak-ground-acceleration alarm controller: debounced trigger, hysteretic release,
// optional operator-acknowledge latching, with per-event channel flags and peak capture.
module pga_alarm_ctrl #(
    parameter int                N_CH          = 3,
    parameter int                DATA_W        = 24,
    parameter logic [DATA_W-1:0] PGA_THRESHOLD = 'h100000,
    parameter logic [DATA_W-1:0] CLR_THRESHOLD = 'h0C0000,
    parameter int                TRIG_COUNT    = 4,
    parameter int                CLR_COUNT     = 8,
    parameter bit                LATCH         = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [N_CH*DATA_W-1:0] i_data,
    input  logic                   i_accept,
    output logic                   o_pga_alarm,
    output logic [N_CH-1:0]        o_ch_flags,
    output logic [DATA_W-1:0]      o_peak,
    output logic [1:0]             o_state
);

    localparam int CNT_MAX = (TRIG_COUNT > CLR_COUNT) ? TRIG_COUNT : CLR_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRIG_C = CNT_W'(TRIG_COUNT);
    localparam logic [CNT_W-1:0] CLR_C  = CNT_W'(CLR_COUNT);

    typedef enum logic [1:0] {
        ARMED   = 2'b00,
        PENDING = 2'b01,
        ALARM   = 2'b10,
        HOLD    = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [N_CH-1:0]    flags, flags_nxt;
    logic [DATA_W-1:0]  peak, peak_nxt;
    logic               alarm;

    logic [N_CH-1:0]    over_vec;
    logic               over, quiet;
    logic [DATA_W-1:0]  smax, ch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        over_vec = '0;
        quiet    = 1'b1;
        smax     = '0;
        ch       = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch          = i_data[i*DATA_W +: DATA_W];
            over_vec[i] = (ch > PGA_THRESHOLD);
            quiet       = quiet & (ch < CLR_THRESHOLD);
            smax        = max_of(smax, ch);
        end
        over = |over_vec;
    end

    assign cnt_inc = sat_inc(cnt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flags_nxt = flags;
        peak_nxt  = peak;
        case (state)
            ARMED, HOLD: begin
                // HOLD behaves like ARMED only on the acknowledge cycle; otherwise frozen.
                if (state == ARMED || i_accept) begin
                    state_nxt = ARMED;
                    cnt_nxt   = '0;
                    flags_nxt = '0;
                    peak_nxt  = '0;
                    if (i_valid && over) begin
                        state_nxt = (TRIG_COUNT == 1) ? ALARM : PENDING;
                        cnt_nxt   = (TRIG_COUNT == 1) ? '0 : CNT_W'(1);
                        flags_nxt = over_vec;
                        peak_nxt  = smax;
                    end
                end
            end
            PENDING: begin
                if (i_valid) begin
                    if (over) begin
                        flags_nxt = flags | over_vec;
                        peak_nxt  = max_of(peak, smax);
                        if (cnt_inc >= TRIG_C) begin
                            state_nxt = ALARM;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end else begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                        flags_nxt = '0;
                        peak_nxt  = '0;
                    end
                end
            end
            ALARM: begin
                if (i_valid) begin
                    flags_nxt = flags | over_vec;
                    peak_nxt  = max_of(peak, smax);
                    if (!quiet) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc >= CLR_C) begin
                        cnt_nxt = '0;
                        if (LATCH) begin
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = ARMED;
                            flags_nxt = '0;
                            peak_nxt  = '0;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARMED;
            cnt   <= '0;
            flags <= '0;
            peak  <= '0;
            alarm <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flags <= flags_nxt;
            peak  <= peak_nxt;
            alarm <= (state_nxt == ALARM) || (state_nxt == HOLD);
        end
    end

    assign o_pga_alarm = alarm;
    assign o_ch_flags  = flags;
    assign o_peak      = peak;
    assign o_state     = state;

endmodule
